// File: rtl/layer1_window_gen.sv
// ---------------------------------------------------------------------------
// layer1_window_gen
//
// Turns a row-major stream of signed layer-1 pixels into 3x3 sliding windows
// (valid-only convolution, no padding) for the 9-input multiply/tree-add path.
// Two line buffers hold the previous two rows; a 3x3 shift register holds the
// current window. One output register, no skid buffer.
//
// Parameters:
//   DATA_W  pixel / window element width (signed)
//   IMG_W   pixels per row (>= 3)
//   IMG_H   rows per frame (>= 3)
//
// Ports:
//   clk                    rising-edge clock
//   rst                    synchronous active-high reset
//   in_valid / in_ready    input handshake (in_ready = !out_valid || out_ready)
//   in_pixel               signed input pixel, row-major
//   out_valid / out_ready  output handshake
//   win_data1..win_data9   window, row-major, win_data1 = (r-2,c-2) .. win_data9 = (r,c)
//   frame_done             one-cycle pulse while the last window is first presented
//   out_row / out_col      output-map coordinate of the presented window
//                          (only when LAYER1_WIN_COORD_EN is defined)
//
// Optional feature macro: LAYER1_WIN_COORD_EN
// ---------------------------------------------------------------------------
module layer1_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] win_data1,
    output logic signed [DATA_W-1:0] win_data2,
    output logic signed [DATA_W-1:0] win_data3,
    output logic signed [DATA_W-1:0] win_data4,
    output logic signed [DATA_W-1:0] win_data5,
    output logic signed [DATA_W-1:0] win_data6,
    output logic signed [DATA_W-1:0] win_data7,
    output logic signed [DATA_W-1:0] win_data8,
    output logic signed [DATA_W-1:0] win_data9,
`ifdef LAYER1_WIN_COORD_EN
    output logic [15:0]              out_row,
    output logic [15:0]              out_col,
`endif
    output logic                     frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
    localparam logic [RW-1:0] ROW_LAST_FILL = RW'(1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    state_q;
    logic [CW-1:0]             col_q, col_d;
    logic [RW-1:0]             row_q, row_d;
    logic                      out_valid_q, out_valid_d;
    logic                      frame_done_q, frame_done_d;

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2 (not reset)
    logic signed [DATA_W-1:0]  lb0_q [IMG_W];
    logic signed [DATA_W-1:0]  lb1_q [IMG_W];

    // 3x3 shift register, index 0 = leftmost column
    logic signed [DATA_W-1:0]  top_q [3];
    logic signed [DATA_W-1:0]  mid_q [3];
    logic signed [DATA_W-1:0]  bot_q [3];

    // Presented window, row-major
    logic signed [DATA_W-1:0]  win_q [9];

    logic                      accept_s;
    logic                      col_last_s;
    logic                      row_last_s;
    logic                      emit_s;
    logic signed [DATA_W-1:0]  lb0_rd_s;
    logic signed [DATA_W-1:0]  lb1_rd_s;
    logic signed [DATA_W-1:0]  nwin_s [9];

`ifdef LAYER1_WIN_COORD_EN
    logic [15:0]               out_row_q;
    logic [15:0]               out_col_q;
`endif

    assign in_ready = !out_valid_q || out_ready;

    // Handshake, line-buffer read and post-shift window
    always_comb begin
        accept_s   = in_valid && in_ready;
        col_last_s = (col_q == COL_LAST);
        row_last_s = (row_q == ROW_LAST);
        lb0_rd_s   = lb0_q[col_q];
        lb1_rd_s   = lb1_q[col_q];
        // In RUN the row is always >= 2, so only the column gates emission
        emit_s     = accept_s && (state_q == ST_RUN) && (col_q >= COL_FIRST_WIN);
        nwin_s[0]  = top_q[1];
        nwin_s[1]  = top_q[2];
        nwin_s[2]  = lb1_rd_s;
        nwin_s[3]  = mid_q[1];
        nwin_s[4]  = mid_q[2];
        nwin_s[5]  = lb0_rd_s;
        nwin_s[6]  = bot_q[1];
        nwin_s[7]  = bot_q[2];
        nwin_s[8]  = in_pixel;
    end

    // Column/row counters and output-valid next state
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        if (accept_s) begin
            if (col_last_s) begin
                col_d = {CW{1'b0}};
                if (row_last_s) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
        if (emit_s) begin
            out_valid_d  = 1'b1;
            frame_done_d = row_last_s && col_last_s;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // FILL/RUN state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept_s && (row_q == ROW_LAST_FILL) && col_last_s) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_FILL;
                    end
                end
                ST_RUN: begin
                    if (accept_s && row_last_s && col_last_s) begin
                        state_q <= ST_FILL;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    // Counters, handshake flags, window shift register and output window
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
                bot_q[i] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            if (accept_s) begin
                for (int i = 0; i < 3; i++) begin
                    top_q[i] <= nwin_s[i];
                    mid_q[i] <= nwin_s[3 + i];
                    bot_q[i] <= nwin_s[6 + i];
                end
            end
            if (emit_s) begin
                for (int i = 0; i < 9; i++) begin
                    win_q[i] <= nwin_s[i];
                end
            end
        end
    end

    // Line-buffer update: lb0 column moves down into lb1, new pixel into lb0
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_q[col_q] <= lb0_rd_s;
            lb0_q[col_q] <= in_pixel;
        end
    end

`ifdef LAYER1_WIN_COORD_EN
    // Output-map coordinate, loaded together with the window
    always_ff @(posedge clk) begin
        if (rst) begin
            out_row_q <= 16'd0;
            out_col_q <= 16'd0;
        end else if (emit_s) begin
            out_row_q <= 16'(row_q) - 16'd2;
            out_col_q <= 16'(col_q) - 16'd2;
        end
    end

    assign out_row = out_row_q;
    assign out_col = out_col_q;
`endif

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign win_data1  = win_q[0];
    assign win_data2  = win_q[1];
    assign win_data3  = win_q[2];
    assign win_data4  = win_q[3];
    assign win_data5  = win_q[4];
    assign win_data6  = win_q[5];
    assign win_data7  = win_q[6];
    assign win_data8  = win_q[7];
    assign win_data9  = win_q[8];

endmodule

// File: doc/layer1_window_gen.md
Name: layer1_window_gen

Overview:
- Produces 3x3 sliding windows from a row-major stream of layer-1 input pixels.
- Each window is presented as nine signed words, win_data1..win_data9, ready for the 9-input layer-1 multiply/tree-add path.
- Uses two line buffers and a 3x3 shift register. Valid-only convolution: no padding, so (IMG_W-2)*(IMG_H-2) windows per frame.
- Valid/ready handshake on both sides.

Parameters:
- DATA_W, 16, pixel and window element width (signed two's complement).
- IMG_W, 28, pixels per row; must be >= 3.
- IMG_H, 28, rows per frame; must be >= 3.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_pixel is valid.
- in_ready  out  1  block accepts in_pixel this cycle.
- in_pixel  in  DATA_W  signed pixel, row-major order.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream consumes the window.
- win_data1..win_data9  out  DATA_W each  window, row-major: win_data1 = (r-2,c-2) … win_data9 = (r,c).
- frame_done  out  1  one-cycle pulse: last window of the frame has been loaded.

Behaviour:
- Accept = in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational). Single output register, no skid buffer.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1; both advance on accept.
  - col wraps to 0 and increments row.
  - At (IMG_H-1, IMG_W-1) both wrap to 0.
- Line buffers lb0 (row r-1) and lb1 (row r-2), each IMG_W deep:
  - On accept at column c: read lb0[c] and lb1[c].
  - Then write lb1[c] <= lb0[c] and lb0[c] <= in_pixel.
- Window shift register:
  - On accept, columns shift left by one.
  - New right column is {lb1[c], lb0[c], in_pixel} (top to bottom).
- State machine:
  - FILL (row < 2): no windows emitted.
  - RUN: window emitted when col >= 2.
  - FILL->RUN on accept of pixel (1, IMG_W-1).
  - RUN->FILL on accept of the last pixel of the frame.
- Emit rule:
  - Accept in RUN with col >= 2 sets out_valid on the next edge, latency 1 cycle.
  - win_data loaded with the post-shift window.
- Columns 0 and 1 of any row never produce a window, so no window spans a row or frame boundary.
- Hold rule: while out_valid && !out_ready, win_data and out_valid stay stable and in_ready = 0.
- Simultaneous consume and produce: if out_valid && out_ready && accept with an emitting pixel, out_valid stays 1 and win_data updates the same edge.
- Consume without a new emitting pixel: out_valid <= 0.
- frame_done:
  - Registered pulse, high exactly one cycle: the cycle out_valid first presents the last window.
  - Cleared the next cycle regardless of out_ready.
- Values pass through bit-exact; no arithmetic, saturation or sign change.
- Reset:
  - out_valid = 0, win_data1..9 = 0, frame_done = 0.
  - row = col = 0, state = FILL.
  - in_ready = 1 after reset.
  - Line-buffer contents are not reset; they are overwritten during FILL before use.
- Reset mid-frame: partial frame and any pending window are discarded. The next accepted pixel is (0,0).

Optional Feature:
LAYER1_WIN_COORD_EN:
- Defined:
  - Adds ports out_row and out_col, each 16-bit unsigned output.
  - They give the output-map coordinate (r-2, c-2) of the presented window.
  - Registered with win_data, held under backpressure; reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 0..15, out_ready=1, in_valid=1 → exactly 4 windows:
  - First is 0,1,2,4,5,6,8,9,10, with out_valid one cycle after pixel 10 is accepted.
  - Then 1,2,3,5,6,7,9,10,11.
  - Then 4,5,6,8,9,10,12,13,14.
  - Then 5,6,7,9,10,11,13,14,15 with frame_done=1.
- Same frame with out_ready=0 for 5 cycles after the first window → in_ready=0, win_data stays 0,1,2,4,5,6,8,9,10. After release, all 4 windows arrive in order with no loss or duplication.
- Pixels alternating -32768 and 32767 (IMG_W=IMG_H=3) → single window with the same bit patterns in matching positions; frame_done=1.
- 4x4 frame: rst high for 1 cycle after 6 pixels accepted, then pixels 100..115 → 4 windows only, first 100,101,102,104,105,106,108,109,110. Nothing from pre-reset pixels.
- Two 4x4 frames back-to-back (0..15 then 16..31, no gap) → 8 windows and two frame_done pulses. Window 5 is 16,17,18,20,21,22,24,25,26.
- With LAYER1_WIN_COORD_EN, 4x4 frame → (out_row,out_col) = (0,0),(0,1),(1,0),(1,1). Without the macro, the design compiles without those ports.
